// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the ROB result port.
// Each requester owns a 2-deep {rob_idx, value} queue; one queue head is drained per
// cycle onto a registered writeback bus (cdb_*). Default scheduling is round-robin.
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest,
// no round-robin pointer).
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 5
`endif

module wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = `ROB_SIZE_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*IDX_W-1:0] req_rob_idx,
    input  logic [NUM_REQ*32-1:0]    req_value,
    output logic                     cdb_valid,
    output logic [IDX_W-1:0]         cdb_rob_idx,
    output logic [31:0]              cdb_value,
    output logic [1:0]               cdb_src
);

    localparam int FIFO_DEPTH = 2;

    // An edge "advances" only when not paused and not flushing.
    logic                     advance;
    logic [3:0]               nonempty;
    logic [NUM_REQ*IDX_W-1:0] head_idx;
    logic [NUM_REQ*32-1:0]    head_val;
    logic                     grant_valid;
    logic [1:0]               grant_idx;
    logic [IDX_W-1:0]         grant_rob_idx;
    logic [31:0]              grant_value;

    logic                     cdb_valid_q, cdb_valid_d;
    logic [IDX_W-1:0]         cdb_rob_idx_q, cdb_rob_idx_d;
    logic [31:0]              cdb_value_q, cdb_value_d;
    logic [1:0]               cdb_src_q, cdb_src_d;

    assign advance = rdy_in && !clear;

    genvar gi;

    // Per-requester queues.
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_q
        logic [IDX_W-1:0] idx_mem_q [FIFO_DEPTH];
        logic [IDX_W-1:0] idx_mem_d [FIFO_DEPTH];
        logic [31:0]      val_mem_q [FIFO_DEPTH];
        logic [31:0]      val_mem_d [FIFO_DEPTH];
        logic             wptr_q, wptr_d;
        logic             rptr_q, rptr_d;
        logic [1:0]       count_q, count_d;
        logic             push;
        logic             pop;

        // Readiness looks only at the current count, so a full queue never
        // accepts on the same edge it pops; reset forces it low.
        assign req_ready[gi] = rst_in && advance && (count_q != 2'd2);
        assign push          = req_valid[gi] && req_ready[gi];
        assign pop           = advance && grant_valid && (grant_idx == 2'(gi));
        assign nonempty[gi]  = (count_q != 2'd0);
        assign head_idx[gi*IDX_W +: IDX_W] = idx_mem_q[rptr_q];
        assign head_val[gi*32 +: 32]       = val_mem_q[rptr_q];

        // Next queue state: flush empties it, push/pop move their own pointers.
        always_comb begin
            idx_mem_d = idx_mem_q;
            val_mem_d = val_mem_q;
            wptr_d    = wptr_q;
            rptr_d    = rptr_q;
            count_d   = count_q;
            if (rdy_in && clear) begin
                wptr_d  = 1'b0;
                rptr_d  = 1'b0;
                count_d = 2'd0;
            end else begin
                if (push) begin
                    idx_mem_d[wptr_q] = req_rob_idx[gi*IDX_W +: IDX_W];
                    val_mem_d[wptr_q] = req_value[gi*32 +: 32];
                    wptr_d            = ~wptr_q;
                end
                if (pop) begin
                    rptr_d = ~rptr_q;
                end
                if (push && !pop) begin
                    count_d = count_q + 2'd1;
                end else if (!push && pop) begin
                    count_d = count_q - 2'd1;
                end
            end
        end

        // Queue state register.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                wptr_q  <= 1'b0;
                rptr_q  <= 1'b0;
                count_q <= 2'd0;
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    idx_mem_q[k] <= '0;
                    val_mem_q[k] <= '0;
                end
            end else begin
                wptr_q    <= wptr_d;
                rptr_q    <= rptr_d;
                count_q   <= count_d;
                idx_mem_q <= idx_mem_d;
                val_mem_q <= val_mem_d;
            end
        end
    end

    // Unused upper scan slots always read as empty.
    for (gi = NUM_REQ; gi < 4; gi++) begin : g_pad
        assign nonempty[gi] = 1'b0;
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered non-empty queue wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (nonempty[2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(k);
            end
        end
    end
`else
    logic [1:0] rr_q, rr_d;
    logic [2:0] scan;

    // Round-robin: first non-empty queue scanning rr, rr+1, ... modulo NUM_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        scan        = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + 3'(k);
            if (scan >= 3'(NUM_REQ)) begin
                scan = scan - 3'(NUM_REQ);
            end
            if (!grant_valid && nonempty[scan[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan[1:0];
            end
        end
    end

    // Pointer moves past the winner; flush restarts the scan at requester 0.
    always_comb begin
        rr_d = rr_q;
        if (rdy_in && clear) begin
            rr_d = 2'd0;
        end else if (advance && grant_valid) begin
            rr_d = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Select the winning queue's head entry.
    always_comb begin
        grant_rob_idx = '0;
        grant_value   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == 2'(k)) begin
                grant_rob_idx = head_idx[k*IDX_W +: IDX_W];
                grant_value   = head_val[k*32 +: 32];
            end
        end
    end

    // Writeback bus next state: data fields hold when there is no winner.
    always_comb begin
        cdb_valid_d   = cdb_valid_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_value_d   = cdb_value_q;
        cdb_src_d     = cdb_src_q;
        if (rdy_in) begin
            if (clear) begin
                cdb_valid_d = 1'b0;
            end else begin
                cdb_valid_d = grant_valid;
                if (grant_valid) begin
                    cdb_rob_idx_d = grant_rob_idx;
                    cdb_value_d   = grant_value;
                    cdb_src_d     = grant_idx;
                end
            end
        end
    end

    // Writeback bus register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_value_q   <= '0;
            cdb_src_q     <= 2'd0;
        end else begin
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_value_q   <= cdb_value_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_value   = cdb_value_q;
    assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-source expected-data queues plus an optional
// expected grant-order queue, popped whenever a writeback beat is observed.
module tb_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int IDX_W   = 5;

    logic                     clk_in = 1'b0;
    logic                     rst_in = 1'b0;
    logic                     rdy_in = 1'b0;
    logic                     clear  = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*IDX_W-1:0] req_rob_idx = '0;
    logic [NUM_REQ*32-1:0]    req_value = '0;
    logic                     cdb_valid;
    logic [IDX_W-1:0]         cdb_rob_idx;
    logic [31:0]              cdb_value;
    logic [1:0]               cdb_src;

    wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rob_idx (req_rob_idx),
        .req_value   (req_value),
        .cdb_valid   (cdb_valid),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    int checks_total = 0;
    int checks_pass  = 0;

    logic [IDX_W+31:0] q0[$];
    logic [IDX_W+31:0] q1[$];
    logic [IDX_W+31:0] q2[$];
    int                order_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input int src, input logic [IDX_W-1:0] idx, input logic [31:0] val);
        case (src)
            0:       q0.push_back({idx, val});
            1:       q1.push_back({idx, val});
            default: q2.push_back({idx, val});
        endcase
    endtask

    task automatic set_req(input int i, input logic v, input logic [IDX_W-1:0] idx, input logic [31:0] val);
        req_valid[i]                 = v;
        req_rob_idx[i*IDX_W +: IDX_W] = idx;
        req_value[i*32 +: 32]         = val;
    endtask

    // One clock; any beat produced by an active edge is scored and printed.
    task automatic cyc();
        logic              en;
        logic              found;
        logic [IDX_W+31:0] e;
        en = rst_in && rdy_in && !clear;
        @(posedge clk_in);
        #1;
        if (en && cdb_valid) begin
            found = 1'b0;
            e     = '0;
            if (order_q.size() != 0) begin
                check("beat_src_order", 64'(cdb_src), 64'(order_q.pop_front()));
            end
            case (cdb_src)
                2'd0: if (q0.size() != 0) begin e = q0.pop_front(); found = 1'b1; end
                2'd1: if (q1.size() != 0) begin e = q1.pop_front(); found = 1'b1; end
                2'd2: if (q2.size() != 0) begin e = q2.pop_front(); found = 1'b1; end
                default: found = 1'b0;
            endcase
            check("beat_expected", 64'(found), 64'd1);
            if (found) begin
                check("beat_data", 64'({cdb_rob_idx, cdb_value}), 64'(e));
            end
            $display("t=%0t beat src=%0d idx=%0d val=0x%0h", $time, cdb_src, cdb_rob_idx, cdb_value);
        end
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_q0"}, 64'(q0.size()), 64'd0);
        check({tag, "_q1"}, 64'(q1.size()), 64'd0);
        check({tag, "_q2"}, 64'(q2.size()), 64'd0);
        check({tag, "_order"}, 64'(order_q.size()), 64'd0);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_n;
        int l_n;
        int cyc_n;

        // ---------------- reset values ----------------
        rst_in = 1'b0;
        rdy_in = 1'b1;
        #2;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cdb_data", 64'({cdb_src, cdb_rob_idx, cdb_value}), 64'd0);
        repeat (2) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        check("rst_rel_ready", 64'(req_ready), 64'b111);
        check("rst_rel_valid", 64'(cdb_valid), 64'd0);

        // ---------------- ALU back-to-back ----------------
        for (int n = 0; n < 6; n++) begin
            set_req(0, 1'b1, 5'(n), 32'(n * 16));
            check("bb_ready0", 64'(req_ready[0]), 64'd1);
            push_exp(0, 5'(n), 32'(n * 16));
            order_q.push_back(0);
            cyc();
            if (n > 0) check("bb_no_gap", 64'(cdb_valid), 64'd1);
        end
        idle_all();
        cyc();
        check("bb_last_beat", 64'(cdb_valid), 64'd1);
        cyc();
        check("bb_idle", 64'(cdb_valid), 64'd0);
        drain_check("bb_drain");

        // ---------------- flush with 5 queued (rr now 1) ----------------
        set_req(0, 1'b1, 5'd1, 32'h101);
        set_req(1, 1'b1, 5'd2, 32'h102);
        set_req(2, 1'b1, 5'd3, 32'h103);
        cyc();
        set_req(0, 1'b1, 5'd4, 32'h104);
        set_req(1, 1'b1, 5'd5, 32'h105);
        set_req(2, 1'b1, 5'd6, 32'h106);
        push_exp(1, 5'd2, 32'h102);
        order_q.push_back(1);
        cyc();
        check("flush_pre_valid", 64'(cdb_valid), 64'd1);
        idle_all();
        clear = 1'b1;
        set_req(0, 1'b1, 5'd7, 32'h107);
        #1;
        check("flush_ready_blocked", 64'(req_ready), 64'd0);
        cyc();
        check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        clear = 1'b0;
        idle_all();
        #1;
        check("flush_ready_after", 64'(req_ready), 64'b111);
        repeat (2) begin
            cyc();
            check("flush_empty", 64'(cdb_valid), 64'd0);
        end
        drain_check("flush_drain");

        // ---------------- round-robin (rr reset to 0 by flush) ----------------
        push_exp(0, 5'd0, 32'hA0); push_exp(1, 5'd2, 32'hB0); push_exp(2, 5'd4, 32'hC0);
        push_exp(0, 5'd1, 32'hA1); push_exp(1, 5'd3, 32'hB1); push_exp(2, 5'd5, 32'hC1);
        for (int i = 0; i < 6; i++) order_q.push_back(i % 3);
        set_req(0, 1'b1, 5'd0, 32'hA0);
        set_req(1, 1'b1, 5'd2, 32'hB0);
        set_req(2, 1'b1, 5'd4, 32'hC0);
        cyc();
        set_req(0, 1'b1, 5'd1, 32'hA1);
        set_req(1, 1'b1, 5'd3, 32'hB1);
        set_req(2, 1'b1, 5'd5, 32'hC1);
        cyc();
        idle_all();
        repeat (6) cyc();
        check("rr_idle", 64'(cdb_valid), 64'd0);
        drain_check("rr_drain");

        // ---------------- backpressure: ALU and LSB both pushing ----------------
        a_n   = 0;
        l_n   = 0;
        cyc_n = 0;
        while ((a_n < 6 || l_n < 4) && cyc_n < 40) begin
            set_req(0, a_n < 6, 5'(16 + a_n), 32'h500 + 32'(a_n));
            set_req(1, l_n < 4, 5'(24 + l_n), 32'h600 + 32'(l_n));
            if (req_valid[0] && req_ready[0]) begin
                push_exp(0, 5'(16 + a_n), 32'h500 + 32'(a_n));
                a_n++;
            end
            if (req_valid[1] && req_ready[1]) begin
                push_exp(1, 5'(24 + l_n), 32'h600 + 32'(l_n));
                l_n++;
            end
            cyc();
            cyc_n++;
            if (cyc_n == 2) check("bp_ready1_full", 64'(req_ready[1]), 64'd0);
        end
        check("bp_all_accepted", 64'({a_n == 6, l_n == 4}), 64'b11);
        idle_all();
        repeat (6) cyc();
        check("bp_idle", 64'(cdb_valid), 64'd0);
        drain_check("bp_drain");

        // ---------------- pause (flush first so rr is 0) ----------------
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        push_exp(0, 5'd10, 32'h1010); push_exp(1, 5'd11, 32'h1111); push_exp(0, 5'd12, 32'h1212);
        order_q.push_back(0); order_q.push_back(1); order_q.push_back(0);
        set_req(0, 1'b1, 5'd10, 32'h1010);
        set_req(1, 1'b1, 5'd11, 32'h1111);
        cyc();
        set_req(0, 1'b1, 5'd12, 32'h1212);
        set_req(1, 1'b0, '0, '0);
        cyc();
        idle_all();
        rdy_in = 1'b0;
        #1;
        check("pause_ready", 64'(req_ready), 64'd0);
        repeat (3) begin
            cyc();
            check("pause_hold", 64'({cdb_valid, cdb_src, cdb_rob_idx, cdb_value}),
                  64'({1'b1, 2'd0, 5'd10, 32'h1010}));
        end
        rdy_in = 1'b1;
        repeat (2) cyc();
        cyc();
        check("pause_idle", 64'(cdb_valid), 64'd0);
        drain_check("pause_drain");

        // ---------------- reset mid-stream ----------------
        push_exp(1, 5'd3, 32'h11);
        order_q.push_back(1);
        set_req(1, 1'b1, 5'd3, 32'h11);
        cyc();
        set_req(1, 1'b1, 5'd4, 32'h22);
        cyc();
        idle_all();
        #3;
        rst_in = 1'b0;
        #1;
        check("mid_rst_valid", 64'(cdb_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_data", 64'({cdb_src, cdb_rob_idx, cdb_value}), 64'd0);
        repeat (2) cyc();
        #3;
        rst_in = 1'b1;
        #1;
        check("mid_rel_ready", 64'(req_ready), 64'b111);
        repeat (3) begin
            cyc();
            check("mid_rel_valid", 64'(cdb_valid), 64'd0);
        end
        drain_check("mid_drain");

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
